// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the 16-bit data bus: data width, destination code
// constants (shared with the main source mux), the write-buffer entry layout
// and the code-to-one-hot destination decode.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_DEST = 10;   // bit 0 = dr, bits 1..9 = r1..r9
    localparam int SEL_W    = 4;

    // Bus source/destination codes. 0 and 1 are the ALU (read-only);
    // 12..15 are unassigned.
    localparam logic [SEL_W-1:0] SEL_ALU0 = 4'd0;
    localparam logic [SEL_W-1:0] SEL_ALU1 = 4'd1;
    localparam logic [SEL_W-1:0] SEL_DR   = 4'd2;
    localparam logic [SEL_W-1:0] SEL_R1   = 4'd3;
    localparam logic [SEL_W-1:0] SEL_R2   = 4'd4;
    localparam logic [SEL_W-1:0] SEL_R3   = 4'd5;
    localparam logic [SEL_W-1:0] SEL_R4   = 4'd6;
    localparam logic [SEL_W-1:0] SEL_R5   = 4'd7;
    localparam logic [SEL_W-1:0] SEL_R6   = 4'd8;
    localparam logic [SEL_W-1:0] SEL_R7   = 4'd9;
    localparam logic [SEL_W-1:0] SEL_R8   = 4'd10;
    localparam logic [SEL_W-1:0] SEL_R9   = 4'd11;

    typedef logic [NUM_DEST-1:0] dest_vec_t;

    // One buffered write: target register (one-hot) and the word to load.
    typedef struct packed {
        dest_vec_t         dest;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    // Codes SEL_DR..SEL_R9 map onto consecutive one-hot bits starting at 0.
    // Any other code returns all zeros, which callers treat as invalid.
    function automatic dest_vec_t dest_onehot(input logic [SEL_W-1:0] sel);
        dest_vec_t oh;
        oh = '0;
        if (sel >= SEL_DR && sel <= SEL_R9) begin
            oh[sel - SEL_DR] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/bus_write_decoder_if.sv
// -----------------------------------------------------------------------------
// bus_write_decoder_if
// Write-request handshake from the bus/control unit into bus_write_decoder.
//   bus_data  : word on the bus to be written
//   dest_sel  : destination code (bus_pkg SEL_* encoding)
//   wr_valid  : request valid
//   wr_ready  : decoder can accept a request
// A request transfers on a rising edge where wr_valid and wr_ready are both 1.
// -----------------------------------------------------------------------------
interface bus_write_decoder_if;
    import bus_pkg::*;

    logic [DATA_W-1:0] bus_data;
    logic [SEL_W-1:0]  dest_sel;
    logic              wr_valid;
    logic              wr_ready;

    modport master (
        output bus_data,
        output dest_sel,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  bus_data,
        input  dest_sel,
        input  wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read (rdata is the current head).
//   clk, rst       : clock, asynchronous active-low reset
//   push, wdata    : write at tail (ignored when full)
//   pop            : drop head (ignored when empty)
//   rdata          : head entry, valid while !empty
//   full, empty    : status from the registered count
//   count          : occupied entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it has
    // been written, and leaving it unreset lets it map onto plain RAM/regfile.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_write_decoder.sv
// -----------------------------------------------------------------------------
// bus_write_decoder
// Return path of the shared data bus: accepts bus words tagged with a
// destination code, buffers them in order and issues one registered load
// enable per cycle to dr / r1..r9, holding a write while its target is busy.
//   clk, rst    : clock, asynchronous active-low reset
//   wr          : write-request handshake (bus_data, dest_sel, wr_valid, wr_ready)
//   dest_busy   : per-destination hold, bit set = cannot load this cycle
//   ld_en       : one-hot load enable, registered
//   ld_data     : data for ld_en, registered, holds when idle
//   err_pulse   : one-cycle pulse after an invalid code was accepted
//   err_count   : saturating count of invalid codes
//   fifo_count  : occupied buffer entries
// -----------------------------------------------------------------------------
module bus_write_decoder
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    bus_write_decoder_if.slave      wr,
    input  logic [NUM_DEST-1:0]     dest_busy,
    output logic [NUM_DEST-1:0]     ld_en,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    err_pulse,
    output logic [7:0]              err_count,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    dest_vec_t  sel_onehot;
    logic       sel_valid;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    wr_entry_t  in_entry;
    wr_entry_t  head;

    assign sel_onehot    = dest_onehot(wr.dest_sel);
    assign sel_valid     = |sel_onehot;
    assign in_entry.dest = sel_onehot;
    assign in_entry.data = wr.bus_data;

    // Ready depends only on the registered count: a pop in the same cycle
    // does not open a slot, which keeps wr_ready free of dest_busy paths.
    assign wr.wr_ready = !fifo_full;
    assign accept      = wr.wr_valid && wr.wr_ready;

    // Invalid codes complete the handshake but never enter the buffer.
    assign push = accept && sel_valid;

    // Strict FIFO: only the head is ever considered, so a busy head blocks
    // everything behind it. dest_busy is irrelevant while empty.
    assign pop = !fifo_empty && ((head.dest & dest_busy) == '0);

    sync_fifo #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_en   <= '0;
            ld_data <= '0;
        end else if (pop) begin
            ld_en   <= head.dest;
            ld_data <= head.data;
        end else begin
            ld_en   <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && !sel_valid;
            if (accept && !sel_valid && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
